// File: rtl/uart_cmd_framer.sv
// rtl/uart_cmd_framer.sv - framed UART byte stream to 64-bit RF command word
//
// Purpose:
//   Collects one frame of serial-port bytes (SOF, 8 payload bytes MSB first,
//   EOF) and presents the payload as a 64-bit command word with a one-cycle
//   valid strobe. Frames with a wrong end byte, or with an idle gap between
//   bytes that is too long, are dropped and counted. Framing is purely
//   length based, so SOF/EOF values inside the payload are ordinary data.
//
// Ports:
//   clk_20mhz      in   1  sole clock, rising edge
//   rst            in   1  asynchronous active-high reset
//   uart_byte_vld  in   1  one-cycle strobe, uart_byte valid
//   uart_byte      in   8  received byte
//   rv_uart_vld    out  1  one-cycle command-valid pulse
//   rv_uart_data   out 64  last good command word, held between frames
//   frame_busy     out  1  frame in progress
//   frame_err_cnt  out  8  discarded-frame count, saturating at 255

module uart_cmd_framer #(
  parameter logic [7:0]  SOF         = 8'hC0,
  parameter logic [7:0]  EOF         = 8'hCF,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic        clk_20mhz,
  input  logic        rst,
  input  logic        uart_byte_vld,
  input  logic [7:0]  uart_byte,
  output logic        rv_uart_vld,
  output logic [63:0] rv_uart_data,
  output logic        frame_busy,
  output logic [7:0]  frame_err_cnt
);

  // Counter only ever needs to reach TIMEOUT_CYC-1.
  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PAYLOAD  = 2'd1,
    ST_WAIT_EOF = 2'd2
  } state_t;

  state_t           state_q;
  logic [2:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      shift_q;
  logic             vld_q;
  logic [63:0]      data_q;
  logic             busy_q;
  logic [7:0]       err_cnt_q;

  logic [7:0]       err_cnt_d;
  logic             timed_out;

  // Saturating increment of the discard counter.
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  // Expiry only counts in a cycle without a byte: an arriving byte always
  // wins over a counter that is about to expire.
  assign timed_out = !uart_byte_vld && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_20mhz or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      shift_q   <= 64'h0;
      vld_q     <= 1'b0;
      data_q    <= 64'h0;
      busy_q    <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      vld_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          // Anything other than SOF between frames is line noise.
          if (uart_byte_vld && (uart_byte == SOF)) begin
            state_q <= ST_PAYLOAD;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_PAYLOAD: begin
          if (uart_byte_vld) begin
            // Byte k lands in bits [63-8k -: 8]; ~idx_q == 7-k.
            shift_q[{~idx_q, 3'b000} +: 8] <= uart_byte;
            idx_q <= idx_q + 3'd1;
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= ST_WAIT_EOF;
            end
          end else if (timed_out) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            err_cnt_q <= err_cnt_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WAIT_EOF: begin
          if (uart_byte_vld) begin
            // Whatever byte arrives here closes the frame; a wrong one is
            // consumed as the bad terminator and never reconsidered as SOF.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (uart_byte == EOF) begin
              data_q <= shift_q;
              vld_q  <= 1'b1;
            end else begin
              err_cnt_q <= err_cnt_d;
            end
          end else if (timed_out) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            err_cnt_q <= err_cnt_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rv_uart_vld   = vld_q;
  assign rv_uart_data  = data_q;
  assign frame_busy    = busy_q;
  assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb/tb_uart_cmd_framer.sv - directed self-checking bench for uart_cmd_framer

module tb_uart_cmd_framer;

  localparam int TO = 20;

  logic        clk_20mhz;
  logic        rst;
  logic        uart_byte_vld;
  logic [7:0]  uart_byte;
  logic        rv_uart_vld;
  logic [63:0] rv_uart_data;
  logic        frame_busy;
  logic [7:0]  frame_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int p0;

  uart_cmd_framer #(
    .SOF(8'hC0),
    .EOF(8'hCF),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_20mhz     (clk_20mhz),
    .rst           (rst),
    .uart_byte_vld (uart_byte_vld),
    .uart_byte     (uart_byte),
    .rv_uart_vld   (rv_uart_vld),
    .rv_uart_data  (rv_uart_data),
    .frame_busy    (frame_busy),
    .frame_err_cnt (frame_err_cnt)
  );

  initial clk_20mhz = 1'b0;
  always #25 clk_20mhz = ~clk_20mhz;

  // Reads the pre-edge value, so each high cycle is counted once.
  always @(posedge clk_20mhz) begin
    if (rv_uart_vld === 1'b1) pulses++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic put(input logic [7:0] b);
    uart_byte_vld = 1'b1;
    uart_byte     = b;
    @(negedge clk_20mhz);
    uart_byte_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    uart_byte_vld = 1'b0;
    repeat (n) @(negedge clk_20mhz);
  endtask

  task automatic send_frame(input logic [63:0] d, input logic [7:0] eofb);
    put(8'hC0);
    for (int k = 0; k < 8; k++) put(d[63-8*k -: 8]);
    put(eofb);
  endtask

  task automatic do_reset();
    uart_byte_vld = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk_20mhz);
    rst = 1'b0;
    @(negedge clk_20mhz);
  endtask

  initial begin
    rst           = 1'b1;
    uart_byte_vld = 1'b0;
    uart_byte     = 8'h00;
    repeat (3) @(negedge clk_20mhz);
    check("rst_vld",  64'(rv_uart_vld),   64'h0);
    check("rst_data", rv_uart_data,       64'h0);
    check("rst_busy", 64'(frame_busy),    64'h0);
    check("rst_err",  64'(frame_err_cnt), 64'h0);
    rst = 1'b0;
    @(negedge clk_20mhz);

    // Good frame, byte by byte
    p0 = pulses;
    put(8'hC0);
    check("busy_rise", 64'(frame_busy), 64'h1);
    put(8'h1A); put(8'h1A); put(8'h00); put(8'h00);
    put(8'h11); put(8'h11); put(8'h00); put(8'h55);
    check("busy_before_eof", 64'(frame_busy), 64'h1);
    check("vld_before_eof",  64'(rv_uart_vld), 64'h0);
    put(8'hCF);
    check("good_vld",  64'(rv_uart_vld),   64'h1);
    check("good_data", rv_uart_data,       64'h1A1A_0000_1111_0055);
    check("good_busy", 64'(frame_busy),    64'h0);
    check("good_err",  64'(frame_err_cnt), 64'h0);
    idle(1);
    check("good_vld_drop", 64'(rv_uart_vld), 64'h0);
    idle(1);
    check("good_pulses", 64'(pulses - p0), 64'd1);

    // Back-to-back frames, SOF right after the EOF cycle
    p0 = pulses;
    send_frame(64'h0123_4567_89AB_CDEF, 8'hCF);
    check("b2b1_data", rv_uart_data, 64'h0123_4567_89AB_CDEF);
    send_frame(64'hFEDC_BA98_7654_3210, 8'hCF);
    check("b2b2_vld",  64'(rv_uart_vld), 64'h1);
    check("b2b2_data", rv_uart_data, 64'hFEDC_BA98_7654_3210);
    idle(2);
    check("b2b_pulses", 64'(pulses - p0), 64'd2);

    // Bad end byte, then a good frame immediately after
    p0 = pulses;
    send_frame(64'hDEAD_BEEF_0000_1111, 8'h00);
    check("bad_vld",  64'(rv_uart_vld),   64'h0);
    check("bad_data", rv_uart_data,       64'hFEDC_BA98_7654_3210);
    check("bad_err",  64'(frame_err_cnt), 64'h1);
    check("bad_busy", 64'(frame_busy),    64'h0);
    send_frame(64'h0102_0304_0506_0708, 8'hCF);
    check("after_bad_vld",  64'(rv_uart_vld),   64'h1);
    check("after_bad_data", rv_uart_data,       64'h0102_0304_0506_0708);
    check("after_bad_err",  64'(frame_err_cnt), 64'h1);
    idle(2);
    check("bad_pulses", 64'(pulses - p0), 64'd1);

    // Idle garbage and embedded markers
    do_reset();
    put(8'h55); put(8'hCF); put(8'h12);
    check("garbage_busy", 64'(frame_busy), 64'h0);
    send_frame(64'hCFC0_CFC0_CFC0_CFC0, 8'hCF);
    check("markers_vld",  64'(rv_uart_vld),   64'h1);
    check("markers_data", rv_uart_data,       64'hCFC0_CFC0_CFC0_CFC0);
    check("markers_err",  64'(frame_err_cnt), 64'h0);

    // Timeout: TO-1 idle clocks keep the frame, the TO-th drops it
    do_reset();
    put(8'hC0); put(8'hA1); put(8'hA2); put(8'hA3);
    idle(TO - 1);
    check("to_edge_busy", 64'(frame_busy),    64'h1);
    check("to_edge_err",  64'(frame_err_cnt), 64'h0);
    idle(1);
    check("to_busy", 64'(frame_busy),    64'h0);
    check("to_err",  64'(frame_err_cnt), 64'h1);
    idle(3);

    // Gaps of exactly TO-1 in PAYLOAD and WAIT_EOF are accepted
    put(8'hC0); put(8'hA1); put(8'hA2); put(8'hA3);
    idle(TO - 1);
    put(8'hA4); put(8'hA5); put(8'hA6); put(8'hA7); put(8'hA8);
    idle(TO - 1);
    put(8'hCF);
    check("gap_vld",  64'(rv_uart_vld),   64'h1);
    check("gap_data", rv_uart_data,       64'hA1A2_A3A4_A5A6_A7A8);
    check("gap_err",  64'(frame_err_cnt), 64'h1);
    idle(1);

    // Reset mid-frame
    put(8'hC0); put(8'h11); put(8'h22); put(8'h33); put(8'h44); put(8'h55);
    rst = 1'b1;
    #1;
    check("midrst_data", rv_uart_data,       64'h0);
    check("midrst_busy", 64'(frame_busy),    64'h0);
    check("midrst_err",  64'(frame_err_cnt), 64'h0);
    check("midrst_vld",  64'(rv_uart_vld),   64'h0);
    @(negedge clk_20mhz);
    rst = 1'b0;
    p0 = pulses;
    put(8'h66); put(8'h77); put(8'h88); put(8'hCF);
    idle(2);
    check("midrst_pulses", 64'(pulses - p0), 64'd0);
    check("midrst_busy2",  64'(frame_busy),  64'h0);
    check("midrst_err2",   64'(frame_err_cnt), 64'h0);
    check("midrst_data2",  rv_uart_data,     64'h0);

    // Saturation
    for (int i = 0; i < 254; i++) send_frame(64'h0, 8'h00);
    check("sat_254", 64'(frame_err_cnt), 64'd254);
    send_frame(64'h0, 8'h00);
    check("sat_255", 64'(frame_err_cnt), 64'd255);
    for (int i = 0; i < 45; i++) send_frame(64'h0, 8'h00);
    check("sat_hold", 64'(frame_err_cnt), 64'd255);
    send_frame(64'h5A5A_A5A5_0F0F_F0F0, 8'hCF);
    check("sat_good_vld",  64'(rv_uart_vld),   64'h1);
    check("sat_good_data", rv_uart_data,       64'h5A5A_A5A5_0F0F_F0F0);
    check("sat_good_err",  64'(frame_err_cnt), 64'd255);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Assembles framed serial-port command bytes into the 64-bit command word and one-cycle valid strobe (`rv_uart_vld` / `rv_uart_data`) consumed by the RF I/O control stage. It sits between the UART byte receiver and the RF control logic, in the `clk_20mhz` domain. Each frame is a start byte, exactly 8 payload bytes (most significant byte first) and an end byte. Malformed or stalled frames are discarded and counted.

## Interface
Parameters:
- `SOF`, 8'hC0, start-of-frame byte.
- `EOF`, 8'hCF, end-of-frame byte.
- `TIMEOUT_CYC`, 200000, maximum idle gap between bytes inside a frame, in clocks (10 ms at 20 MHz). Must be ≥ 2.

Ports:
- `clk_20mhz` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `uart_byte_vld` in 1: one-cycle strobe, received byte valid.
- `uart_byte` in 8: received byte, sampled when `uart_byte_vld`=1.
- `rv_uart_vld` out 1: one-cycle command-valid pulse.
- `rv_uart_data` out 64: last good command word; held between frames.
- `frame_busy` out 1: high while a frame is in progress (state ≠ IDLE).
- `frame_err_cnt` out 8: count of discarded frames, saturating.

## Operation
- States: IDLE, PAYLOAD, WAIT_EOF. All outputs are registered.
- IDLE:
  - A byte equal to `SOF` → PAYLOAD, byte index ← 0, timeout counter ← 0.
  - Any other byte is ignored. No error is counted.
- PAYLOAD:
  - Each valid byte is written to shift register bits [63-8k -: 8], k = byte index 0..7.
  - After index 7 → WAIT_EOF.
  - Payload bytes equal to `SOF` or `EOF` are plain data. Framing is length-based with no escaping.
- WAIT_EOF:
  - Byte equal to `EOF` → `rv_uart_data` ← shift register, `rv_uart_vld` ← 1 for one cycle, → IDLE.
  - Any other byte → frame discarded, `frame_err_cnt` +1, → IDLE. That byte is not re-examined as a `SOF`.
- Timeout:
  - In PAYLOAD or WAIT_EOF, the counter increments every clock with no valid byte and clears on each valid byte.
  - When the counter reaches `TIMEOUT_CYC`-1: discard the frame, `frame_err_cnt` +1, → IDLE.
  - If a byte arrives in the same cycle the counter would expire, the byte wins: it is processed and the counter clears.
- `frame_err_cnt` saturates at 255. It is cleared only by `rst`.
- A discarded frame never changes `rv_uart_data`.

## Timing
- Reset values: state IDLE, `rv_uart_vld`=0, `rv_uart_data`=64'h0, `frame_busy`=0, `frame_err_cnt`=0, shift register 0, counter 0.
- Latency: `rv_uart_vld` is high in the cycle after the clock edge that samples the `EOF` byte. `rv_uart_data` is valid in that same cycle and stays stable until the next good frame.
- `frame_busy` rises in the cycle after `SOF` is sampled. It falls in the cycle after `EOF`, an error or a timeout.
- Back-to-back bytes (`uart_byte_vld` high on consecutive clocks) are supported at full rate. A `SOF` in the cycle right after `EOF` starts a new frame.
- `rst` asserted mid-frame: outputs take their reset values immediately, and the partial frame is lost. Deasserting `rst` is not an error.
- Minimum frame length is 10 bytes. The minimum spacing between `rv_uart_vld` pulses is 10 clocks.

## Test plan
- Good frame: C0, 1A 1A 00 00 11 11 00 55, CF on consecutive clocks → one-cycle `rv_uart_vld` one clock after CF; `rv_uart_data`=64'h1A1A_0000_1111_0055; `frame_err_cnt`=0.
- Bad end byte: C0, 8 payload bytes, 00 → no `rv_uart_vld`; `rv_uart_data` unchanged; `frame_err_cnt`=1; a following good frame is decoded correctly.
- Idle garbage and embedded markers: bytes 55 CF 12, then frame C0, CF C0 CF C0 CF C0 CF C0, CF → `rv_uart_data`=64'hCFC0_CFC0_CFC0_CFC0; `frame_err_cnt`=0.
- Timeout: C0 and 3 payload bytes, then silence ≥ `TIMEOUT_CYC` → `frame_busy` drops, `frame_err_cnt`=1. Separately, a gap of exactly `TIMEOUT_CYC`-1 clocks before the next byte → that byte is accepted with no error.
- Reset mid-frame: C0 and 5 payload bytes, pulse `rst` → all outputs at reset values; the remaining bytes and CF produce no `rv_uart_vld`.
- Saturation: 300 bad-EOF frames → `frame_err_cnt`=255 and stays there; good frames still decode.
